// File: rtl/xor_pkg.sv
// Shared definitions for the XOR checksum sequencer: state encoding and
// default datapath widths.
package xor_pkg;

    localparam int unsigned XOR_DATA_W = 8;
    localparam int unsigned XOR_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/xor_word.sv
// Combinational W-bit two-input XOR; the shared datapath element.
// Ports: a, b - operands; y - a ^ b.
module xor_word #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_checksum_ctrl.sv
// Sequencer that folds a job of `len` words from a valid/ready stream into an
// XOR accumulator and presents checksum + parity on a valid/ready output.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start, len, busy      - job request / length / not-idle indicator
//   in_valid, in_data,
//   in_ready              - input word stream
//   out_valid, out_ready,
//   checksum, parity      - result handshake, XOR of words and its parity
module xor_checksum_ctrl
    import xor_pkg::*;
#(
    parameter int unsigned DATA_W = XOR_DATA_W,
    parameter int unsigned LEN_W  = XOR_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] checksum,
    output logic              parity
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [LEN_W-1:0]    r_rem;
    logic                r_parity;
    logic                r_busy;
    logic                r_in_ready;
    logic                r_out_valid;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [LEN_W-1:0]    w_rem_nxt;
    logic [DATA_W-1:0]   w_xor;
    logic                w_beat;
    logic                w_par_chain [DATA_W];

    // Shared datapath: acc ^ in_data
    xor_word #(.W(DATA_W)) u_xor (
        .a (r_acc),
        .b (in_data),
        .y (w_xor)
    );

    // Parity of the next accumulator value, so it lands in step with r_acc
    assign w_par_chain[0] = w_acc_nxt[0];
    for (genvar i = 1; i < DATA_W; i++) begin : g_par
        xor_word #(.W(1)) u_par (
            .a (w_par_chain[i-1]),
            .b (w_acc_nxt[i]),
            .y (w_par_chain[i])
        );
    end

    assign w_beat = in_valid & r_in_ready;

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_acc_nxt = '0;
                    if (len != '0) begin
                        w_state_nxt = ACCUM;
                        w_rem_nxt   = len;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            ACCUM: begin
                if (w_beat) begin
                    w_acc_nxt = w_xor;
                    w_rem_nxt = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags (decoded from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_parity    <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_rem       <= w_rem_nxt;
            r_parity    <= w_par_chain[DATA_W-1];
            r_busy      <= (w_state_nxt != IDLE);
            r_in_ready  <= (w_state_nxt == ACCUM);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    assign busy      = r_busy;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign checksum  = r_acc;
    assign parity    = r_parity;

endmodule
